// File: rtl/soc_iobus.sv
// soc_iobus: decodes the 8-bit core bus onto RAM, the video read port and a bank of I/O registers.
// Define SOC_IOBUS_DEBOUNCE_EN to add a stability filter on each synchronised key.
module soc_iobus #(
  parameter int          ADDR_W    = 16,
  parameter int          RAM_AW    = 15,
  parameter logic [15:0] IO_BASE   = 16'hFFF0,
  parameter logic [15:0] VBASE_RST = 16'h2800,
  parameter int          TIMER_DIV = 25000,
  parameter int          NKEYS     = 2,
  parameter int          SCAN_W    = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [7:0]        cpu_out,
  input  logic              cpu_we,
  output logic [7:0]        cpu_in,
  output logic [RAM_AW-1:0] ram_address,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  input  logic [7:0]        ram_q,
  input  logic [ADDR_W-1:0] vga_address,
  output logic [RAM_AW-1:0] vid_address,
  output logic [3:0]        led,
  input  logic [NKEYS-1:0]  keys,
  output logic [7:0]        hex,
  output logic [3:0]        en7,
  output logic              irq
);

  localparam logic [ADDR_W-1:0] IO_BASE_A = ADDR_W'(IO_BASE);
  localparam int VW = (ADDR_W > 16) ? ADDR_W : 16;
  localparam int PW = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TIMER_DIV - 1);

  localparam logic [1:0] SEL_RAM  = 2'd0;
  localparam logic [1:0] SEL_IO   = 2'd1;
  localparam logic [1:0] SEL_NONE = 2'd2;

  localparam logic [3:0] OFF_LED     = 4'd0;
  localparam logic [3:0] OFF_KEYS    = 4'd1;
  localparam logic [3:0] OFF_KEYEDGE = 4'd2;
  localparam logic [3:0] OFF_VB_LO   = 4'd3;
  localparam logic [3:0] OFF_VB_HI   = 4'd4;
  localparam logic [3:0] OFF_TM_LO   = 4'd5;
  localparam logic [3:0] OFF_TM_HI   = 4'd6;
  localparam logic [3:0] OFF_HEX_LO  = 4'd7;
  localparam logic [3:0] OFF_HEX_HI  = 4'd8;

  logic              io_hit;
  logic              ram_hit;
  logic              io_we;
  logic [3:0]        offset;
  logic              timer_rd;
  logic              timer_clr;
  logic              tick;

  logic [1:0]        sel_reg;
  logic [7:0]        io_rdata_reg;
  logic [7:0]        io_rdata_next;

  logic [3:0]        led_reg;
  logic [15:0]       vbase_reg;
  logic [15:0]       hexval_reg;

  logic [NKEYS-1:0]  key_sync1_reg;
  logic [NKEYS-1:0]  key_sync2_reg;
  logic [NKEYS-1:0]  key_level;
  logic [NKEYS-1:0]  key_prev_reg;
  logic [NKEYS-1:0]  edge_reg;
  logic [NKEYS-1:0]  edge_clr;
  logic [NKEYS-1:0]  edge_next;

  logic [PW-1:0]     presc_reg;
  logic [15:0]       ms_reg;
  logic [7:0]        shadow_reg;
  logic              irq_reg;

  logic [SCAN_W-1:0] scan_reg;
  logic [1:0]        digit;
  logic [3:0]        nibble;
  logic [6:0]        seg;

  // Address decode
  assign offset  = cpu_address[3:0];
  assign io_hit  = (cpu_address[ADDR_W-1:4] == IO_BASE_A[ADDR_W-1:4]);
  assign ram_hit = ((cpu_address >> RAM_AW) == '0) && !io_hit;
  assign io_we   = cpu_we && io_hit;

  assign ram_address = cpu_address[RAM_AW-1:0];
  assign ram_data    = cpu_out;
  assign ram_we      = cpu_we && ram_hit && reset_n;

  assign vid_address = RAM_AW'(VW'(vga_address) + VW'(vbase_reg));

  // Writable I/O registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      led_reg    <= '0;
      vbase_reg  <= VBASE_RST;
      hexval_reg <= '0;
    end else if (io_we) begin
      case (offset)
        OFF_LED:    led_reg          <= cpu_out[3:0];
        OFF_VB_LO:  vbase_reg[7:0]   <= cpu_out;
        OFF_VB_HI:  vbase_reg[15:8]  <= cpu_out;
        OFF_HEX_LO: hexval_reg[7:0]  <= cpu_out;
        OFF_HEX_HI: hexval_reg[15:8] <= cpu_out;
        default:    ;
      endcase
    end
  end

  assign led = led_reg;

  // Key synchronisers rest at the released (high) level
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_sync1_reg <= '1;
      key_sync2_reg <= '1;
    end else begin
      key_sync1_reg <= keys;
      key_sync2_reg <= key_sync1_reg;
    end
  end

`ifdef SOC_IOBUS_DEBOUNCE_EN
  logic [NKEYS-1:0] key_filt_reg;
  logic [11:0]      db_cnt_reg [NKEYS];

  // Filtered level follows the synchroniser only after 4096 steady clocks
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_filt_reg <= '1;
      for (int i = 0; i < NKEYS; i++) db_cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (key_sync2_reg[i] == key_filt_reg[i]) begin
          db_cnt_reg[i] <= '0;
        end else if (db_cnt_reg[i] == 12'hFFF) begin
          key_filt_reg[i] <= key_sync2_reg[i];
          db_cnt_reg[i]   <= '0;
        end else begin
          db_cnt_reg[i] <= db_cnt_reg[i] + 12'd1;
        end
      end
    end
  end

  assign key_level = ~key_filt_reg;
`else
  assign key_level = ~key_sync2_reg;
`endif

  // A fresh press wins over a simultaneous clear
  assign edge_clr  = (io_we && offset == OFF_KEYEDGE) ? cpu_out[NKEYS-1:0] : '0;
  assign edge_next = (edge_reg & ~edge_clr) | (key_level & ~key_prev_reg);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_prev_reg <= '0;
      edge_reg     <= '0;
    end else begin
      key_prev_reg <= key_level;
      edge_reg     <= edge_next;
    end
  end

  // Millisecond timer; a write to TIMER_LO restarts the count
  assign timer_clr = io_we && offset == OFF_TM_LO;
  assign timer_rd  = io_hit && !cpu_we && offset == OFF_TM_LO;
  assign tick      = !timer_clr && presc_reg == PRESC_MAX;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc_reg <= '0;
      ms_reg    <= '0;
      irq_reg   <= 1'b0;
    end else begin
      irq_reg <= tick;
      if (timer_clr) begin
        presc_reg <= '0;
        ms_reg    <= '0;
      end else if (tick) begin
        presc_reg <= '0;
        ms_reg    <= ms_reg + 16'd1;
      end else begin
        presc_reg <= presc_reg + PW'(1);
      end
    end
  end

  assign irq = irq_reg;

  always_comb begin
    io_rdata_next = 8'h00;
    case (offset)
      OFF_LED:     io_rdata_next = {4'h0, led_reg};
      OFF_KEYS:    io_rdata_next = 8'(key_level);
      OFF_KEYEDGE: io_rdata_next = 8'(edge_reg);
      OFF_VB_LO:   io_rdata_next = vbase_reg[7:0];
      OFF_VB_HI:   io_rdata_next = vbase_reg[15:8];
      OFF_TM_LO:   io_rdata_next = ms_reg[7:0];
      OFF_TM_HI:   io_rdata_next = shadow_reg;
      OFF_HEX_LO:  io_rdata_next = hexval_reg[7:0];
      OFF_HEX_HI:  io_rdata_next = hexval_reg[15:8];
      default:     io_rdata_next = 8'h00;
    endcase
  end

  // Read path: every target answers one cycle after the address
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_reg      <= SEL_NONE;
      io_rdata_reg <= '0;
      shadow_reg   <= '0;
    end else begin
      io_rdata_reg <= io_rdata_next;
      if (io_hit)       sel_reg <= SEL_IO;
      else if (ram_hit) sel_reg <= SEL_RAM;
      else              sel_reg <= SEL_NONE;
      if (timer_rd) shadow_reg <= ms_reg[15:8];
    end
  end

  always_comb begin
    case (sel_reg)
      SEL_RAM: cpu_in = ram_q;
      SEL_IO:  cpu_in = io_rdata_reg;
      default: cpu_in = 8'hFF;
    endcase
  end

  // 7-segment scanner
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) scan_reg <= '0;
    else          scan_reg <= scan_reg + SCAN_W'(1);
  end

  assign digit  = scan_reg[SCAN_W-1 -: 2];
  assign nibble = hexval_reg[{digit, 2'b00} +: 4];
  assign en7    = ~(4'b0001 << digit);

  // Segment order {g,f,e,d,c,b,a}, active-low
  always_comb begin
    case (nibble)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
  end

  assign hex = {1'b1, seg};

endmodule

// File: tb/tb_soc_iobus.sv
// Directed self-checking bench for soc_iobus with a fast timer and short scan counter.
module tb_soc_iobus;

  logic        clock;
  logic        reset_n;
  logic [15:0] cpu_address;
  logic [7:0]  cpu_out;
  logic        cpu_we;
  logic [7:0]  cpu_in;
  logic [14:0] ram_address;
  logic [7:0]  ram_data;
  logic        ram_we;
  logic [7:0]  ram_q;
  logic [15:0] vga_address;
  logic [14:0] vid_address;
  logic [3:0]  led;
  logic [1:0]  keys;
  logic [7:0]  hex;
  logic [3:0]  en7;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int irq_count;
  int n;

  logic [7:0] mem [0:32767];

  soc_iobus #(
    .ADDR_W(16), .RAM_AW(15), .IO_BASE(16'hFFF0), .VBASE_RST(16'h2800),
    .TIMER_DIV(4), .NKEYS(2), .SCAN_W(4)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cpu_address(cpu_address), .cpu_out(cpu_out), .cpu_we(cpu_we), .cpu_in(cpu_in),
    .ram_address(ram_address), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
    .vga_address(vga_address), .vid_address(vid_address),
    .led(led), .keys(keys), .hex(hex), .en7(en7), .irq(irq)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Synchronous RAM model, read-before-write
  always @(posedge clock) begin
    if (ram_we) mem[ram_address] <= ram_data;
    ram_q <= mem[ram_address];
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    cpu_address = a;
    cpu_out     = d;
    cpu_we      = 1'b1;
    cyc();
    cpu_we      = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a);
    cpu_address = a;
    cpu_we      = 1'b0;
    cyc();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n     = 1'b0;
    cpu_address = 16'h0000;
    cpu_out     = 8'h00;
    cpu_we      = 1'b0;
    vga_address = 16'h0000;
    keys        = 2'b11;
    cyc(); cyc(); cyc();

    check("rst_cpu_in", cpu_in, 8'hFF);
    check("rst_led", led, 4'h0);
    check("rst_irq", irq, 1'b0);
    check("rst_vid", vid_address, 15'h2800);
    check("rst_en7", en7, 4'b1110);
    check("rst_hex", hex, 8'hC0);
    reset_n = 1'b1;
    #1;
    check("post_rst_cpu_in", cpu_in, 8'hFF);

    // RAM write then read
    cpu_address = 16'h0100; cpu_out = 8'h5A; cpu_we = 1'b1;
    #1;
    check("ram_we_pulse", ram_we, 1'b1);
    check("ram_addr", ram_address, 15'h0100);
    cyc();
    cpu_we = 1'b0;
    #1;
    check("ram_we_low", ram_we, 1'b0);
    rd(16'h0100);
    check("ram_read", cpu_in, 8'h5A);

    // LED register
    wr(16'hFFF0, 8'hA7);
    check("led_out", led, 4'h7);
    rd(16'hFFF0);
    check("led_read", cpu_in, 8'h07);

    // Video base
    wr(16'hFFF3, 8'h00);
    wr(16'hFFF4, 8'h40);
    vga_address = 16'h4123;
    #1;
    check("vid_wrap", vid_address, 15'h0123);
    rd(16'hFFF4);
    check("vbase_hi_read", cpu_in, 8'h40);

    // Key level and edge latch
    keys = 2'b10;
    cpu_address = 16'hFFF1;
    for (int i = 0; i < 10; i++) cyc();
    check("keys_level", cpu_in, 8'h01);
    keys = 2'b11;
    cyc(); cyc(); cyc();
    rd(16'hFFF2);
    check("keyedge_set", cpu_in, 8'h01);
    wr(16'hFFF2, 8'h01);
    rd(16'hFFF2);
    check("keyedge_clear", cpu_in, 8'h00);
    cyc(); cyc();
    keys = 2'b10;
    cyc(); cyc();
    wr(16'hFFF2, 8'h01);
    rd(16'hFFF2);
    check("keyedge_clr_vs_edge", cpu_in, 8'h01);
    keys = 2'b11;

    // Timer: restart, count 300 ticks
    wr(16'hFFF5, 8'h00);
    cpu_address = 16'h0000;
    irq_count = 0;
    for (int i = 0; i < 1200; i++) begin
      cyc();
      if (irq === 1'b1) irq_count++;
    end
    check("irq_count", irq_count, 300);
    rd(16'hFFF5);
    check("timer_lo", cpu_in, 8'h2C);
    cpu_address = 16'h0000;
    for (int i = 0; i < 40; i++) cyc();
    rd(16'hFFF6);
    check("timer_hi_shadow", cpu_in, 8'h01);

    // 7-segment display
    wr(16'hFFF7, 8'h34);
    wr(16'hFFF8, 8'h12);
    rd(16'hFFF7);
    check("hex_lo_read", cpu_in, 8'h34);
    n = 0;
    while (en7 !== 4'b0111 && n < 64) begin cyc(); n++; end
    check("scan_reach_d3", en7, 4'b0111);
    n = 0;
    while (en7 !== 4'b1110 && n < 64) begin cyc(); n++; end
    check("en7_d0", en7, 4'b1110);
    check("hex_d0", hex, 8'h99);
    cyc(); cyc(); cyc();
    check("en7_d0_hold", en7, 4'b1110);
    cyc();
    check("en7_d1", en7, 4'b1101);
    check("hex_d1", hex, 8'hB0);
    cyc(); cyc(); cyc(); cyc();
    check("en7_d2", en7, 4'b1011);
    check("hex_d2", hex, 8'hA4);
    cyc(); cyc(); cyc(); cyc();
    check("en7_d3", en7, 4'b0111);
    check("hex_d3", hex, 8'hF9);

    // Unmapped and reserved addresses
    rd(16'h9000);
    check("unmapped_read", cpu_in, 8'hFF);
    cpu_address = 16'h9000; cpu_out = 8'h77; cpu_we = 1'b1;
    #1;
    check("unmapped_we", ram_we, 1'b0);
    cyc();
    cpu_we = 1'b0;
    rd(16'hFFF9);
    check("reserved_read", cpu_in, 8'h00);

    // Asynchronous reset mid-write
    wr(16'hFFF0, 8'h0C);
    check("led_before_rst", led, 4'hC);
    cpu_address = 16'h0100; cpu_out = 8'h11; cpu_we = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rst_ram_we_gated", ram_we, 1'b0);
    check("rst_led_async", led, 4'h0);
    check("rst_cpu_in_async", cpu_in, 8'hFF);
    check("rst_vid_async", vid_address, 15'h6923);
    cpu_we = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
